// File: rtl/ps2_keys_pkg.sv
// Scancodes and key classes shared by the PS/2 digit-entry block.
// Scancodes are 9 bits wide; bit 8 marks an E0-extended code.
package ps2_keys_pkg;

  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_ENTER, K_BKSP, K_ESC} key_class_e;

  // Index i holds the scancode that types digit i.
  localparam logic [9:0][8:0] SC_TOP = {9'h046, 9'h03E, 9'h03D, 9'h036, 9'h02E,
                                        9'h025, 9'h026, 9'h01E, 9'h016, 9'h045};
  localparam logic [9:0][8:0] SC_PAD = {9'h07D, 9'h075, 9'h06C, 9'h074, 9'h073,
                                        9'h06B, 9'h07A, 9'h072, 9'h069, 9'h070};

  localparam logic [8:0] SC_ENTER    = 9'h05A;
  localparam logic [8:0] SC_KP_ENTER = 9'h15A;
  localparam logic [8:0] SC_BKSP     = 9'h066;
  localparam logic [8:0] SC_ESC      = 9'h076;

endpackage

// File: rtl/ps2_digit_entry_if.sv
// Key-event inputs and entry-buffer outputs of ps2_digit_entry.
// master drives key events (decoder side); slave is the entry block.
interface ps2_digit_entry_if #(
  parameter int DIGITS = 4
);
  localparam int CW = $clog2(DIGITS + 1);

  logic                  been_ready;
  logic [511:0]          key_down;
  logic [8:0]            last_change;
  logic [4*DIGITS-1:0]   nums;
  logic [CW-1:0]         count;
  logic [4*DIGITS-1:0]   value;
  logic                  value_valid;
  logic                  overflow;

  modport master (
    output been_ready, key_down, last_change,
    input  nums, count, value, value_valid, overflow
  );

  modport slave (
    input  been_ready, key_down, last_change,
    output nums, count, value, value_valid, overflow
  );
endinterface

// File: rtl/ps2_key_classify.sv
// Combinational scancode classifier: maps a scancode to a key class
// and, for digit keys, the digit value.
module ps2_key_classify
  import ps2_keys_pkg::*;
#(
  parameter bit NUMPAD_EN = 1'b1
) (
  input  logic [8:0]  last_change,
  output key_class_e  key_class,
  output logic [3:0]  digit
);

  always_comb begin
    key_class = K_NONE;
    digit     = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (last_change == SC_TOP[i] || (NUMPAD_EN && last_change == SC_PAD[i])) begin
        key_class = K_DIGIT;
        digit     = 4'(i);
      end
    end
    if (last_change == SC_ENTER || (NUMPAD_EN && last_change == SC_KP_ENTER)) begin
      key_class = K_ENTER;
    end else if (last_change == SC_BKSP) begin
      key_class = K_BKSP;
    end else if (last_change == SC_ESC) begin
      key_class = K_ESC;
    end
  end

endmodule

// File: rtl/ps2_digit_entry.sv
// Multi-digit BCD entry buffer driven by PS/2 key events, with typematic
// repeat filtering, backspace, clear and a commit pulse.
module ps2_digit_entry
  import ps2_keys_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter bit NUMPAD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  ps2_digit_entry_if.slave   kb
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int W  = 4 * DIGITS;

  key_class_e      key_class;
  logic [3:0]      digit;

  logic [W-1:0]    nums_q, nums_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    value_q, value_d;
  logic            value_valid_q, value_valid_d;
  logic            overflow_q, overflow_d;
  logic [8:0]      held_q, held_d;
  logic            armed_q, armed_d;
  logic            press;
  logic            accept;

  ps2_key_classify #(.NUMPAD_EN(NUMPAD_EN)) u_classify (
    .last_change (kb.last_change),
    .key_class   (key_class),
    .digit       (digit)
  );

  // The repeat check uses the pre-update filter state, so a release seen
  // this cycle only re-arms for the next event.
  assign press  = kb.been_ready && kb.key_down[kb.last_change];
  assign accept = press && (!armed_q || kb.last_change != held_q);

  always_comb begin
    nums_d        = nums_q;
    count_d       = count_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    overflow_d    = 1'b0;
    held_d        = held_q;
    armed_d       = armed_q;
    if (accept) begin
      held_d  = kb.last_change;
      armed_d = 1'b1;
      case (key_class)
        K_DIGIT: begin
          if (count_q < CW'(DIGITS)) begin
            nums_d  = (nums_q << 4) | W'(digit);
            count_d = count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        K_BKSP: begin
          if (count_q != '0) begin
            nums_d  = nums_q >> 4;
            count_d = count_q - CW'(1);
          end
        end
        K_ENTER: begin
          if (count_q != '0) begin
            value_d       = nums_q;
            value_valid_d = 1'b1;
            nums_d        = '0;
            count_d       = '0;
          end
        end
        K_ESC: begin
          nums_d  = '0;
          count_d = '0;
        end
        default: ;
      endcase
    end else if (!kb.key_down[held_q]) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nums_q        <= '0;
      count_q       <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      held_q        <= 9'd0;
      armed_q       <= 1'b0;
    end else begin
      nums_q        <= nums_d;
      count_q       <= count_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      overflow_q    <= overflow_d;
      held_q        <= held_d;
      armed_q       <= armed_d;
    end
  end

  assign kb.nums        = nums_q;
  assign kb.count       = count_q;
  assign kb.value       = value_q;
  assign kb.value_valid = value_valid_q;
  assign kb.overflow    = overflow_q;

endmodule

// File: doc/ps2_digit_entry.md
# ps2_digit_entry

Parametrised successor to the single-key PS/2 decoder stage. It turns KeyboardDecoder key events into a multi-digit numeric entry buffer with backspace, clear and commit, and adds press-edge filtering so typematic repeats do not duplicate digits. It sits between KeyboardDecoder and the display/game logic: the live buffer drives seven-segment or LED digits, and a committed value is handed downstream with a one-cycle valid pulse.

## Interface
- DIGITS, 4: buffer depth in BCD digits, at least 1.
- NUMPAD_EN, 1: 1 = numpad digits and keypad Enter also accepted; 0 = top row and main Enter only.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- been_ready  in  1  one-cycle key-event strobe from KeyboardDecoder.
- key_down  in  512  per-scancode held map from KeyboardDecoder.
- last_change  in  9  scancode of the event; bit 8 = E0 extended.
- nums  out  4*DIGITS  live BCD buffer; digit 0 (bits 3:0) is the most recently typed.
- count  out  $clog2(DIGITS+1)  number of digits currently entered.
- value  out  4*DIGITS  last committed buffer.
- value_valid  out  1  one-cycle pulse when value updates.
- overflow  out  1  one-cycle pulse when a digit is rejected because the buffer is full.

## Operation
- Press event: been_ready=1 and key_down[last_change]=1. Release events (key_down bit 0) are ignored apart from re-arming.
- Repeat filter: held_code (9b) and armed flag.
  - A press is accepted only if !armed or last_change != held_code.
  - On acceptance: held_code <= last_change, armed <= 1.
  - When key_down[held_code]=0: armed <= 0.
- Key classes:
  - Digits: top row 0x45,16,1E,26,25,2E,36,3D,3E,46 = 0..9. Numpad 0x70,69,72,7A,6B,73,74,6C,75,7D = 0..9 when NUMPAD_EN=1.
  - ENTER: 0x05A, or 0x15A when NUMPAD_EN=1.
  - BKSP: 0x066.
  - ESC: 0x076.
  - Anything else is ignored but still updates the repeat filter.
- DIGIT, count<DIGITS: nums <= {nums[4*DIGITS-5:0], d}; count+1.
- DIGIT, count==DIGITS: no change to nums or count; overflow pulses.
- BKSP, count>0: nums <= {4'h0, nums[4*DIGITS-1:4]}; count-1.
- BKSP, count==0: no-op.
- ENTER, count>0: value <= nums; value_valid pulses; nums <= 0; count <= 0.
- ENTER, count==0: no-op; no pulse.
- ESC: nums <= 0; count <= 0; value unchanged.
- Unused digit positions always read 0. count is the authority on what is entered.

## Timing
- All outputs are registered. Effects appear on the first clk edge after the cycle in which been_ready=1, giving 1-cycle latency.
- Reset values: nums=0, count=0, value=0, value_valid=0, overflow=0, held_code=0, armed=0.
- value_valid and overflow are high for exactly one cycle per qualifying event and are never both high.
- At most one event per cycle is processed. been_ready on consecutive cycles is processed back to back.
- Re-arm versus new press in the same cycle: the press check uses the pre-update armed and held_code values.
- rst mid-entry discards the buffer and any pending pulse. The next cycle behaves as post-reset.

## Structure
- Package ps2_keys_pkg holds:
  - 9-bit scancode localparams for digits, ENTER, KP_ENTER, BKSP and ESC.
  - Key-class enum {K_NONE, K_DIGIT, K_ENTER, K_BKSP, K_ESC}.
- Sub-module ps2_key_classify: combinational. Inputs last_change and NUMPAD_EN. Outputs class and 4-bit digit value.
- Top level holds the repeat filter, the buffer shift/count datapath and the pulse registers.

## Test plan
- Reset, then press/release "1","2","3" (0x16,0x1E,0x26) -> nums=0x0123, count=3, no pulses.
- Hold "5" (0x2E) with three repeated make events -> exactly one digit 5 is entered. Release, then press again -> second 5 accepted.
- DIGITS=4: type 1,2,3,4,5 -> nums=0x1234, count=4, overflow pulses once on the 5th key. Then BKSP -> nums=0x0123, count=3.
- Type 9,8 then ENTER (0x05A) -> value=0x0098 and value_valid high for one cycle; nums=0, count=0. ENTER on empty buffer -> no pulse.
- NUMPAD_EN=1: numpad 7 (0x6C) then keypad Enter (0x15A) -> value=0x0007. NUMPAD_EN=0: same stimulus -> nothing changes.
- Type 4,2 then ESC -> nums=0, count=0, value keeps its previous commit. Assert rst mid-entry -> all outputs 0 the next cycle.
